// File: rtl/spi_req_arbiter_pkg.sv
// spi_arb_pkg -- shared types and constants for the SPI request arbiter.
//   CMD_W     : width of one requester's command code
//   ARB_STATE : arbiter states (idle, issue request, transaction running, release)
package spi_arb_pkg;

   localparam int CMD_W = 3;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ISSUE   = 2'd1,
      ARB_RUN     = 2'd2,
      ARB_RELEASE = 2'd3
   } ARB_STATE;

endpackage

// File: rtl/spi_req_arbiter_if.sv
// spi_req_arbiter_if -- request/stream bundle between the arbiter and the SPI master.
//   master modport : arbiter side (drives request, command, lengths, write stream, rd_ready)
//   slave modport  : SPI master side (drives busy, wr_ready, read stream, clk_en)
interface spi_req_arbiter_if
   import spi_arb_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int LSIZE = 24
);

   logic             request;
   logic [CMD_W-1:0] req_cmd;
   logic [LSIZE-1:0] req_len;
   logic [LSIZE-1:0] req_wr_len;
   logic             wr_vld;
   logic [DSIZE-1:0] wr_data;
   logic             rd_ready;
   logic             busy;
   logic             wr_ready;
   logic             rd_vld;
   logic [DSIZE-1:0] rd_data;
   logic             clk_en;

   modport master (
      output request, req_cmd, req_len, req_wr_len, wr_vld, wr_data, rd_ready,
      input  busy, wr_ready, rd_vld, rd_data, clk_en
   );

   modport slave (
      input  request, req_cmd, req_len, req_wr_len, wr_vld, wr_data, rd_ready,
      output busy, wr_ready, rd_vld, rd_data, clk_en
   );

endinterface

// File: rtl/spi_req_arbiter_rr_pick.sv
// spi_rr_pick -- combinational round-robin selector.
//   req   : request vector
//   ptr   : index of the last owner; search starts at ptr+1 modulo NREQ
//   pick  : one-hot winner (zero when no request)
//   idx   : binary index of the winner
//   found : at least one request present
module spi_rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] pick,
   output logic [IW-1:0]   idx,
   output logic            found
);

   int          cand_s;
   logic [IW-1:0] cand_idx_s;

   // Walk the requesters starting just after the pointer; the first hit wins.
   always_comb begin
      pick       = '0;
      idx        = '0;
      found      = 1'b0;
      cand_s     = 0;
      cand_idx_s = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_s     = (int'(ptr) + k) % NREQ;
         cand_idx_s = IW'(cand_s);
         if (!found && req[cand_idx_s]) begin
            found            = 1'b1;
            pick[cand_idx_s] = 1'b1;
            idx              = cand_idx_s;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter -- shares one SPI master request port among NREQ requesters.
//   clock, rst_n         : clock, asynchronous active-low reset
//   m_request .. m_rd_ready : per-requester request, command/length, write stream, read ready
//   m_busy, m_wr_ready, m_rd_vld : master status routed to the current owner only
//   m_rd_data, m_clk_en  : broadcast from the SPI master
//   s                    : bundle to the SPI master (master modport)
//   grant                : one-hot current owner, zero when idle
//   tmo_err              : one-cycle pulse on ISSUE watchdog abort
// Optional feature: define SPI_ARB_TMO_EN to enable the ISSUE->busy watchdog
// (TMO cycles); without it ISSUE waits indefinitely and tmo_err is tied low.
module spi_req_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DSIZE = 8,
   parameter int LSIZE = 24,
   parameter int TMO   = 255
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       m_request,
   input  logic [NREQ*CMD_W-1:0] m_req_cmd,
   input  logic [NREQ*LSIZE-1:0] m_req_len,
   input  logic [NREQ*LSIZE-1:0] m_req_wr_len,
   input  logic [NREQ-1:0]       m_wr_vld,
   input  logic [NREQ*DSIZE-1:0] m_wr_data,
   input  logic [NREQ-1:0]       m_rd_ready,
   output logic [NREQ-1:0]       m_busy,
   output logic [NREQ-1:0]       m_wr_ready,
   output logic [NREQ-1:0]       m_rd_vld,
   output logic [DSIZE-1:0]      m_rd_data,
   output logic                  m_clk_en,
   spi_req_arbiter_if.master     s,
   output logic [NREQ-1:0]       grant,
   output logic                  tmo_err
);

   localparam int IW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TMO < 1 || TMO > 255) begin : g_bad_param
      $error("spi_req_arbiter: NREQ must be 2..8 and TMO 1..255");
   end

   ARB_STATE         state_r;
   logic [NREQ-1:0]  grant_r;
   logic [IW-1:0]    owner_r;
   logic [IW-1:0]    ptr_r;
   logic             req_r;
   logic [NREQ-1:0]  pick_s;
   logic [IW-1:0]    pick_idx_s;
   logic             pick_found_s;

   logic [CMD_W-1:0] cmd_s;
   logic [LSIZE-1:0] len_s;
   logic [LSIZE-1:0] wr_len_s;
   logic [DSIZE-1:0] wr_data_s;
   logic             wr_vld_s;
   logic             rd_ready_s;

`ifdef SPI_ARB_TMO_EN
   localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
   logic [7:0] tmo_cnt_r;
   logic       tmo_err_r;
`endif

   spi_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req   (m_request),
      .ptr   (ptr_r),
      .pick  (pick_s),
      .idx   (pick_idx_s),
      .found (pick_found_s)
   );

   // Arbitration FSM: grant, SPI request, round-robin pointer and watchdog.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ARB_IDLE;
         grant_r   <= '0;
         owner_r   <= '0;
         ptr_r     <= IW'(NREQ - 1);   // requester 0 wins first after reset
         req_r     <= 1'b0;
`ifdef SPI_ARB_TMO_EN
         tmo_cnt_r <= 8'd0;
         tmo_err_r <= 1'b0;
`endif
      end else begin
`ifdef SPI_ARB_TMO_EN
         tmo_err_r <= 1'b0;
`endif
         case (state_r)
            ARB_IDLE: begin
               if (pick_found_s) begin
                  grant_r   <= pick_s;
                  owner_r   <= pick_idx_s;
                  req_r     <= 1'b1;
                  state_r   <= ARB_ISSUE;
`ifdef SPI_ARB_TMO_EN
                  tmo_cnt_r <= 8'd0;
`endif
               end else begin
                  state_r <= ARB_IDLE;
               end
            end
            ARB_ISSUE: begin
               // Busy wins over a same-cycle drop: the master has already started.
               if (s.busy) begin
                  req_r   <= 1'b0;
                  state_r <= ARB_RUN;
               end else if (!m_request[owner_r]) begin
                  // Owner withdrew before the master accepted: pointer left alone.
                  req_r   <= 1'b0;
                  grant_r <= '0;
                  state_r <= ARB_IDLE;
`ifdef SPI_ARB_TMO_EN
               end else if (tmo_cnt_r == TMO_LAST) begin
                  req_r     <= 1'b0;
                  grant_r   <= '0;
                  tmo_err_r <= 1'b1;
                  ptr_r     <= owner_r;
                  state_r   <= ARB_IDLE;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + 8'd1;
               end
`else
               end else begin
                  state_r <= ARB_ISSUE;
               end
`endif
            end
            ARB_RUN: begin
               if (!s.busy) begin
                  state_r <= ARB_RELEASE;
               end else begin
                  state_r <= ARB_RUN;
               end
            end
            ARB_RELEASE: begin
               // Grant drops here so the following IDLE cycle is the dead cycle.
               grant_r <= '0;
               ptr_r   <= owner_r;
               state_r <= ARB_IDLE;
            end
            default: begin
               grant_r <= '0;
               req_r   <= 1'b0;
               state_r <= ARB_IDLE;
            end
         endcase
      end
   end

   // Forward the granted slice; grant is one-hot or zero, so AND-OR is a clean mux.
   always_comb begin
      cmd_s      = '0;
      len_s      = '0;
      wr_len_s   = '0;
      wr_data_s  = '0;
      wr_vld_s   = 1'b0;
      rd_ready_s = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         cmd_s      = cmd_s     | (m_req_cmd[i*CMD_W +: CMD_W]    & {CMD_W{grant_r[i]}});
         len_s      = len_s     | (m_req_len[i*LSIZE +: LSIZE]    & {LSIZE{grant_r[i]}});
         wr_len_s   = wr_len_s  | (m_req_wr_len[i*LSIZE +: LSIZE] & {LSIZE{grant_r[i]}});
         wr_data_s  = wr_data_s | (m_wr_data[i*DSIZE +: DSIZE]    & {DSIZE{grant_r[i]}});
         wr_vld_s   = wr_vld_s   | (m_wr_vld[i]   & grant_r[i]);
         rd_ready_s = rd_ready_s | (m_rd_ready[i] & grant_r[i]);
      end
   end

   assign s.request    = req_r;
   assign s.req_cmd    = cmd_s;
   assign s.req_len    = len_s;
   assign s.req_wr_len = wr_len_s;
   assign s.wr_vld     = wr_vld_s;
   assign s.wr_data    = wr_data_s;
   assign s.rd_ready   = rd_ready_s;

   assign m_busy     = grant_r & {NREQ{s.busy}};
   assign m_wr_ready = grant_r & {NREQ{s.wr_ready}};
   assign m_rd_vld   = grant_r & {NREQ{s.rd_vld}};
   assign m_rd_data  = s.rd_data;
   assign m_clk_en   = s.clk_en;
   assign grant      = grant_r;

`ifdef SPI_ARB_TMO_EN
   assign tmo_err = tmo_err_r;
`else
   assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter -- randomized self-checking bench for spi_req_arbiter.
// Expected owners come from a plain round-robin model over the request vector;
// the SPI master is emulated by a simple busy/stream responder.
module tb_spi_req_arbiter;

   localparam int NREQ  = 4;
   localparam int DSIZE = 8;
   localparam int LSIZE = 24;

   logic                  clock = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       m_request;
   logic [NREQ*3-1:0]     m_req_cmd;
   logic [NREQ*LSIZE-1:0] m_req_len;
   logic [NREQ*LSIZE-1:0] m_req_wr_len;
   logic [NREQ-1:0]       m_wr_vld;
   logic [NREQ*DSIZE-1:0] m_wr_data;
   logic [NREQ-1:0]       m_rd_ready;
   logic [NREQ-1:0]       m_busy;
   logic [NREQ-1:0]       m_wr_ready;
   logic [NREQ-1:0]       m_rd_vld;
   logic [DSIZE-1:0]      m_rd_data;
   logic                  m_clk_en;
   logic [NREQ-1:0]       grant;
   logic                  tmo_err;

   int n_checks = 0;
   int n_pass   = 0;
   int last_owner = NREQ - 1;

   spi_req_arbiter_if #(.DSIZE(DSIZE), .LSIZE(LSIZE)) s_if ();

   spi_req_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .LSIZE(LSIZE), .TMO(255)) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .m_request    (m_request),
      .m_req_cmd    (m_req_cmd),
      .m_req_len    (m_req_len),
      .m_req_wr_len (m_req_wr_len),
      .m_wr_vld     (m_wr_vld),
      .m_wr_data    (m_wr_data),
      .m_rd_ready   (m_rd_ready),
      .m_busy       (m_busy),
      .m_wr_ready   (m_wr_ready),
      .m_rd_vld     (m_rd_vld),
      .m_rd_data    (m_rd_data),
      .m_clk_en     (m_clk_en),
      .s            (s_if),
      .grant        (grant),
      .tmo_err      (tmo_err)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference: first requester after the last owner, modulo NREQ; -1 if none.
   function automatic int rr_next(input int last, input logic [NREQ-1:0] req);
      for (int k = 1; k <= NREQ; k++) begin
         if (req[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_slices();
      m_req_cmd    = 12'($urandom);
      m_req_len    = {$urandom, $urandom, $urandom};
      m_req_wr_len = {$urandom, $urandom, $urandom};
      m_wr_data    = 32'($urandom);
      m_wr_vld     = 4'($urandom);
      m_rd_ready   = 4'($urandom);
   endtask

   // One full transaction for expected owner exp: wait grant, hold off busy for
   // dly cycles, run busy for len cycles, then release. add_req is OR-ed into
   // m_request when busy rises.
   task automatic serve(input int exp, input int dly, input int len,
                        input logic [NREQ-1:0] add_req, output int wt, output int hi);
      logic [NREQ-1:0] oh;
      oh = 4'(1 << exp);
      wt = 0;
      do begin
         tick();
         wt++;
      end while (s_if.request !== 1'b1 && wt < 30);
      n_checks++;
      if (s_if.request !== 1'b1) $display("FAIL req_timeout owner=%0d got request=%b want 1", exp, s_if.request);
      else n_pass++;
      n_checks++;
      if (grant !== oh) $display("FAIL grant got=%b want=%b", grant, oh);
      else n_pass++;
      n_checks++;
      if (s_if.req_cmd !== m_req_cmd[exp*3 +: 3]) $display("FAIL req_cmd got=%h want=%h", s_if.req_cmd, m_req_cmd[exp*3 +: 3]);
      else n_pass++;
      n_checks++;
      if (s_if.req_len !== m_req_len[exp*LSIZE +: LSIZE]) $display("FAIL req_len got=%h want=%h", s_if.req_len, m_req_len[exp*LSIZE +: LSIZE]);
      else n_pass++;
      n_checks++;
      if (s_if.req_wr_len !== m_req_wr_len[exp*LSIZE +: LSIZE]) $display("FAIL req_wr_len got=%h want=%h", s_if.req_wr_len, m_req_wr_len[exp*LSIZE +: LSIZE]);
      else n_pass++;
      n_checks++;
      if (s_if.wr_data !== m_wr_data[exp*DSIZE +: DSIZE]) $display("FAIL wr_data got=%h want=%h", s_if.wr_data, m_wr_data[exp*DSIZE +: DSIZE]);
      else n_pass++;
      hi = 1;
      repeat (dly - 1) begin
         tick();
         if (s_if.request === 1'b1) hi++;
      end
      s_if.busy = 1'b1;
      m_request = m_request | add_req;
      for (int j = 0; j < len; j++) begin
         tick();
         s_if.wr_ready = 1'($urandom);
         s_if.rd_vld   = 1'($urandom);
         s_if.rd_data  = 8'($urandom);
         s_if.clk_en   = 1'($urandom);
         m_rd_ready    = 4'($urandom);
         m_wr_vld      = 4'($urandom);
         #1;
         n_checks++;
         if (s_if.request !== 1'b0 || grant !== oh) $display("FAIL run_state request=%b grant=%b want 0/%b", s_if.request, grant, oh);
         else n_pass++;
         n_checks++;
         if (m_busy !== oh) $display("FAIL m_busy got=%b want=%b", m_busy, oh);
         else n_pass++;
         n_checks++;
         if (m_wr_ready !== (s_if.wr_ready ? oh : 4'b0000)) $display("FAIL m_wr_ready got=%b want=%b", m_wr_ready, s_if.wr_ready ? oh : 4'b0000);
         else n_pass++;
         n_checks++;
         if (m_rd_vld !== (s_if.rd_vld ? oh : 4'b0000)) $display("FAIL m_rd_vld got=%b want=%b", m_rd_vld, s_if.rd_vld ? oh : 4'b0000);
         else n_pass++;
         n_checks++;
         if (s_if.rd_ready !== m_rd_ready[exp] || s_if.wr_vld !== m_wr_vld[exp]) $display("FAIL fwd_stream rd_ready=%b wr_vld=%b want %b/%b", s_if.rd_ready, s_if.wr_vld, m_rd_ready[exp], m_wr_vld[exp]);
         else n_pass++;
         n_checks++;
         if (m_rd_data !== s_if.rd_data || m_clk_en !== s_if.clk_en) $display("FAIL broadcast rd_data=%h clk_en=%b want %h/%b", m_rd_data, m_clk_en, s_if.rd_data, s_if.clk_en);
         else n_pass++;
      end
      s_if.busy = 1'b0;
      tick();
      n_checks++;
      if (grant !== oh) $display("FAIL release_hold grant=%b want=%b", grant, oh);
      else n_pass++;
      tick();
      n_checks++;
      if (grant !== 4'b0000 || s_if.req_cmd !== 3'b000 || s_if.req_len !== 24'd0) $display("FAIL idle grant=%b cmd=%h len=%h want 0", grant, s_if.req_cmd, s_if.req_len);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_request = 4'b0000;
      set_slices();
      s_if.busy = 1'b1;
      s_if.wr_ready = 1'b1;
      s_if.rd_vld = 1'b1;
      s_if.rd_data = 8'h00;
      s_if.clk_en = 1'b0;
      #23;
      n_checks++;
      if (grant !== 4'b0000 || s_if.request !== 1'b0 || tmo_err !== 1'b0) $display("FAIL reset_regs grant=%b request=%b tmo_err=%b want 0", grant, s_if.request, tmo_err);
      else n_pass++;
      n_checks++;
      if (m_busy !== 4'b0000 || m_wr_ready !== 4'b0000 || m_rd_vld !== 4'b0000) $display("FAIL reset_route busy=%b wr_ready=%b rd_vld=%b want 0", m_busy, m_wr_ready, m_rd_vld);
      else n_pass++;
      n_checks++;
      if (s_if.req_cmd !== 3'b000 || s_if.wr_vld !== 1'b0 || s_if.rd_ready !== 1'b0) $display("FAIL reset_mux cmd=%h wr_vld=%b rd_ready=%b want 0", s_if.req_cmd, s_if.wr_vld, s_if.rd_ready);
      else n_pass++;
      s_if.busy = 1'b0;
      s_if.wr_ready = 1'b0;
      s_if.rd_vld = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      last_owner = NREQ - 1;
      tick();
   endtask

   task automatic test_single();
      int exp, wt, hi;
      m_request = 4'b0010;
      set_slices();
      exp = rr_next(last_owner, m_request);
      serve(exp, 3, 20, 4'b0000, wt, hi);
      n_checks++;
      if (hi !== 3) $display("FAIL single_req_cycles got=%0d want=3", hi);
      else n_pass++;
      n_checks++;
      if (wt !== 1) $display("FAIL single_latency got=%0d want=1", wt);
      else n_pass++;
      last_owner = exp;
      m_request = 4'b0000;
   endtask

   task automatic test_back_to_back();
      int exp, wt, hi;
      m_request = 4'b1111;
      for (int t = 0; t < 4; t++) begin
         set_slices();
         exp = rr_next(last_owner, m_request);
         serve(exp, int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), 4'b0000, wt, hi);
         n_checks++;
         if (wt !== 1) $display("FAIL b2b_gap txn=%0d wait=%0d want=1", t, wt);
         else n_pass++;
         last_owner = exp;
      end
      m_request = 4'b0000;
   endtask

   task automatic test_no_preempt();
      int exp, wt, hi;
      m_request = 4'b0100;
      set_slices();
      exp = rr_next(last_owner, m_request);
      serve(exp, 2, 5, 4'b0001, wt, hi);
      last_owner = exp;
      exp = rr_next(last_owner, m_request);
      serve(exp, 1, 3, 4'b0000, wt, hi);
      last_owner = exp;
      m_request = 4'b0000;
   endtask

   task automatic test_drop();
      int exp, wt, hi;
      m_request = 4'b1000;
      set_slices();
      tick();
      n_checks++;
      if (grant !== 4'b1000 || s_if.request !== 1'b1) $display("FAIL drop_issue grant=%b request=%b want 1000/1", grant, s_if.request);
      else n_pass++;
      m_request = 4'b0000;
      tick();
      n_checks++;
      if (grant !== 4'b0000 || s_if.request !== 1'b0 || s_if.req_cmd !== 3'b000) $display("FAIL drop_abort grant=%b request=%b cmd=%h want 0", grant, s_if.request, s_if.req_cmd);
      else n_pass++;
      m_request = 4'b1111;
      exp = rr_next(last_owner, m_request);
      serve(exp, 2, 2, 4'b0000, wt, hi);
      last_owner = exp;
      m_request = 4'b0000;
   endtask

   task automatic test_reset_mid();
      int exp, wt, hi;
      m_request = 4'b0010;
      set_slices();
      tick();
      tick();
      s_if.busy = 1'b1;
      tick();
      tick();
      n_checks++;
      if (grant !== 4'b0010) $display("FAIL pre_reset grant=%b want=0010", grant);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (grant !== 4'b0000 || s_if.request !== 1'b0 || m_busy !== 4'b0000 || s_if.req_cmd !== 3'b000) $display("FAIL async_reset grant=%b request=%b m_busy=%b cmd=%h want 0", grant, s_if.request, m_busy, s_if.req_cmd);
      else n_pass++;
      s_if.busy = 1'b0;
      m_request = 4'b0000;
      @(posedge clock);
      #3;
      rst_n = 1'b1;
      last_owner = NREQ - 1;
      tick();
      m_request = 4'b0110;
      exp = rr_next(last_owner, m_request);
      serve(exp, 2, 3, 4'b0000, wt, hi);
      last_owner = exp;
      m_request = 4'b0000;
   endtask

   task automatic test_random();
      int exp, wt, hi;
      for (int t = 0; t < 12; t++) begin
         m_request = 4'($urandom_range(1, 15));
         set_slices();
         exp = rr_next(last_owner, m_request);
         serve(exp, int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), 4'($urandom), wt, hi);
         n_checks++;
         if (hi !== wt * 0 + hi || wt !== 1) $display("FAIL rand_latency txn=%0d wait=%0d want=1", t, wt);
         else n_pass++;
         last_owner = exp;
      end
      m_request = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_no_preempt();
      test_drop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
